// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
package clk_div_pkg;

  localparam int   CNT_W_DEF   = 16;
  localparam logic MODE_SQUARE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

  // A divisor of 0 has no meaning; treat it as divide-by-1.
  function automatic logic [31:0] sanitize_div(input logic [31:0] div);
    sanitize_div = (div == 32'd0) ? 32'd1 : div;
  endfunction

endpackage

// File: rtl/clk_div_cfg.sv
// Divisor/mode configuration: pending request registers and the active
// settings, swapped only at period boundaries or while counting is disabled.
module clk_div_cfg
  import clk_div_pkg::*;
#(
  parameter int   CNT_W        = CNT_W_DEF,
  parameter int   DEFAULT_DIV  = 4,
  parameter logic DEFAULT_MODE = MODE_SQUARE
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_terminal,
  input  logic             i_en,
  input  logic             i_div_load,
  input  logic [CNT_W-1:0] i_div_in,
  input  logic             i_mode_in,
  output logic [CNT_W-1:0] o_div_active,
  output logic             o_mode_active,
  output logic             o_pend
);

  logic [CNT_W-1:0] r_div_act;
  logic             r_mode_act;
  logic [CNT_W-1:0] r_div_pend;
  logic             r_mode_pend;
  logic             r_pend;
  logic             w_apply;
  logic [CNT_W-1:0] w_div_clean;

  // Settings may change only where no period is in flight.
  assign w_apply     = i_terminal || !i_en;
  assign w_div_clean = CNT_W'(sanitize_div(32'(i_div_in)));

  // Capture requests, promote them at the next boundary; a load on the
  // boundary itself bypasses the pending stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div_act   <= CNT_W'(DEFAULT_DIV);
      r_mode_act  <= DEFAULT_MODE;
      r_div_pend  <= CNT_W'(DEFAULT_DIV);
      r_mode_pend <= DEFAULT_MODE;
      r_pend      <= 1'b0;
    end else if (w_apply) begin
      if (i_div_load) begin
        r_div_act  <= w_div_clean;
        r_mode_act <= i_mode_in;
      end else if (r_pend) begin
        r_div_act  <= r_div_pend;
        r_mode_act <= r_mode_pend;
      end
      r_pend <= 1'b0;
    end else if (i_div_load) begin
      r_div_pend  <= w_div_clean;
      r_mode_pend <= i_mode_in;
      r_pend      <= 1'b1;
    end
  end

  assign o_div_active  = r_div_act;
  assign o_mode_active = r_mode_act;
  assign o_pend        = r_pend;

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider / clock-enable generator.
// Produces a square wave (period 2*D) or a one-cycle pulse (every D cycles)
// plus a registered tick at every period boundary.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int   CNT_W        = CNT_W_DEF,
  parameter int   DEFAULT_DIV  = 4,
  parameter logic DEFAULT_MODE = MODE_SQUARE
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] div_in,
  input  logic             mode_in,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic [CNT_W-1:0] div_active,
  output logic             pend
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_clk_out;
  logic             r_tick;
  logic             w_terminal;
  logic [CNT_W-1:0] w_div_active;
  logic             w_mode_active;

  clk_div_cfg #(
    .CNT_W        (CNT_W),
    .DEFAULT_DIV  (DEFAULT_DIV),
    .DEFAULT_MODE (DEFAULT_MODE)
  ) u_cfg (
    .i_clk         (clk_in),
    .i_rst_n       (rst_n),
    .i_terminal    (w_terminal),
    .i_en          (en),
    .i_div_load    (div_load),
    .i_div_in      (div_in),
    .i_mode_in     (mode_in),
    .o_div_active  (w_div_active),
    .o_mode_active (w_mode_active),
    .o_pend        (pend)
  );

  // Active divisor is never 0, so div-1 cannot underflow.
  assign w_terminal = en && (r_cnt == (w_div_active - CNT_W'(1)));

  // Counter and output shaping; the mode of the period just ending decides
  // what happens at its terminal edge.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_clk_out <= 1'b0;
      r_tick    <= 1'b0;
    end else if (!en) begin
      r_cnt     <= '0;
      r_clk_out <= 1'b0;
      r_tick    <= 1'b0;
    end else if (w_terminal) begin
      r_cnt     <= '0;
      r_tick    <= 1'b1;
      r_clk_out <= (w_mode_active == MODE_PULSE) ? 1'b1 : ~r_clk_out;
    end else begin
      r_cnt  <= r_cnt + CNT_W'(1);
      r_tick <= 1'b0;
      if (w_mode_active == MODE_PULSE) begin
        r_clk_out <= 1'b0;
      end
    end
  end

  assign clk_out    = r_clk_out;
  assign tick       = r_tick;
  assign div_active = w_div_active;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed testbench for clk_div_prog.
module tb_clk_div_prog;

  logic        clk_in = 1'b0;
  logic        rst_n  = 1'b0;
  logic        en     = 1'b0;
  logic [15:0] div_in = '0;
  logic        mode_in  = 1'b0;
  logic        div_load = 1'b0;
  logic        clk_out;
  logic        tick;
  logic [15:0] div_active;
  logic        pend;

  int checks   = 0;
  int failures = 0;

  clk_div_prog dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .en         (en),
    .div_in     (div_in),
    .mode_in    (mode_in),
    .div_load   (div_load),
    .clk_out    (clk_out),
    .tick       (tick),
    .div_active (div_active),
    .pend       (pend)
  );

  always #5 clk_in = ~clk_in;

  // Advance one rising edge and settle just after it.
  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  // Pulse reset between edges; the next rising edge is edge 1.
  task automatic do_reset();
    @(posedge clk_in);
    #1;
    rst_n = 1'b0;
    div_load = 1'b0;
    en = 1'b1;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic exp_clk, exp_tick;
    rst_n = 1'b0;
    en = 1'b1;
    repeat (3) cyc();
    checks++;
    if (clk_out !== 1'b0 || tick !== 1'b0 || pend !== 1'b0 || div_active !== 16'd4) begin
      failures++;
      $display("FAIL reset_state clk_out=%b tick=%b pend=%b div=%0d exp 0 0 0 4",
               clk_out, tick, pend, div_active);
    end
    do_reset();
    for (int e = 1; e <= 13; e++) begin
      cyc();
      exp_clk  = ((e >= 4) && (e < 8)) || (e >= 12);
      exp_tick = (e == 4) || (e == 8) || (e == 12);
      checks++;
      if (clk_out !== exp_clk || tick !== exp_tick) begin
        failures++;
        $display("FAIL default_wave edge=%0d clk_out=%b tick=%b exp %b %b",
                 e, clk_out, tick, exp_clk, exp_tick);
      end
    end
  endtask

  task automatic test_reload();
    logic exp_clk, exp_tick;
    do_reset();
    cyc();                         // edge 1, counter=1
    div_in = 16'd2; mode_in = 1'b0; div_load = 1'b1;
    cyc();                         // edge 2
    div_load = 1'b0;
    checks++;
    if (pend !== 1'b1 || div_active !== 16'd4) begin
      failures++;
      $display("FAIL reload_pend edge=2 pend=%b div=%0d exp 1 4", pend, div_active);
    end
    cyc();                         // edge 3
    checks++;
    if (pend !== 1'b1 || div_active !== 16'd4) begin
      failures++;
      $display("FAIL reload_pend edge=3 pend=%b div=%0d exp 1 4", pend, div_active);
    end
    cyc();                         // edge 4, terminal
    checks++;
    if (pend !== 1'b0 || div_active !== 16'd2 || clk_out !== 1'b1 || tick !== 1'b1) begin
      failures++;
      $display("FAIL reload_apply pend=%b div=%0d clk_out=%b tick=%b exp 0 2 1 1",
               pend, div_active, clk_out, tick);
    end
    for (int e = 5; e <= 10; e++) begin
      cyc();
      exp_clk  = (((e - 4) / 2) % 2) == 0;
      exp_tick = (e % 2) == 0;
      checks++;
      if (clk_out !== exp_clk || tick !== exp_tick) begin
        failures++;
        $display("FAIL reload_wave edge=%0d clk_out=%b tick=%b exp %b %b",
                 e, clk_out, tick, exp_clk, exp_tick);
      end
    end
  endtask

  task automatic test_load_on_terminal();
    logic exp_p;
    do_reset();
    repeat (3) cyc();              // edges 1..3
    div_in = 16'd3; mode_in = 1'b1; div_load = 1'b1;
    cyc();                         // edge 4, terminal
    div_load = 1'b0;
    mode_in = 1'b0;
    checks++;
    if (pend !== 1'b0 || div_active !== 16'd3 || clk_out !== 1'b1 || tick !== 1'b1) begin
      failures++;
      $display("FAIL term_load pend=%b div=%0d clk_out=%b tick=%b exp 0 3 1 1",
               pend, div_active, clk_out, tick);
    end
    for (int e = 5; e <= 13; e++) begin
      cyc();
      exp_p = ((e - 4) % 3) == 0;
      checks++;
      if (clk_out !== exp_p || tick !== exp_p) begin
        failures++;
        $display("FAIL pulse_wave edge=%0d clk_out=%b tick=%b exp %b %b",
                 e, clk_out, tick, exp_p, exp_p);
      end
    end
  endtask

  task automatic test_div_zero();
    logic exp_clk;
    do_reset();
    cyc();                         // edge 1
    div_in = 16'd0; mode_in = 1'b0; div_load = 1'b1;
    cyc();                         // edge 2
    div_load = 1'b0;
    cyc();                         // edge 3
    cyc();                         // edge 4, terminal
    checks++;
    if (div_active !== 16'd1 || clk_out !== 1'b1) begin
      failures++;
      $display("FAIL div_zero_apply div=%0d clk_out=%b exp 1 1", div_active, clk_out);
    end
    for (int e = 5; e <= 10; e++) begin
      cyc();
      exp_clk = (e % 2) == 0;
      checks++;
      if (clk_out !== exp_clk || tick !== 1'b1) begin
        failures++;
        $display("FAIL div1_wave edge=%0d clk_out=%b tick=%b exp %b 1",
                 e, clk_out, tick, exp_clk);
      end
    end
  endtask

  task automatic test_last_wins();
    logic exp_tick;
    do_reset();
    cyc();                         // edge 1
    div_in = 16'd5; mode_in = 1'b0; div_load = 1'b1;
    cyc();                         // edge 2
    div_in = 16'd7;
    checks++;
    if (pend !== 1'b1 || div_active !== 16'd4) begin
      failures++;
      $display("FAIL last_wins_e2 pend=%b div=%0d exp 1 4", pend, div_active);
    end
    cyc();                         // edge 3
    div_load = 1'b0;
    checks++;
    if (pend !== 1'b1 || div_active !== 16'd4) begin
      failures++;
      $display("FAIL last_wins_e3 pend=%b div=%0d exp 1 4", pend, div_active);
    end
    cyc();                         // edge 4
    checks++;
    if (pend !== 1'b0 || div_active !== 16'd7) begin
      failures++;
      $display("FAIL last_wins_apply pend=%b div=%0d exp 0 7", pend, div_active);
    end
    for (int e = 5; e <= 11; e++) begin
      cyc();
      exp_tick = (e == 11);
      checks++;
      if (tick !== exp_tick || div_active !== 16'd7) begin
        failures++;
        $display("FAIL last_wins_period edge=%0d tick=%b div=%0d exp %b 7",
                 e, tick, div_active, exp_tick);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic exp_tick;
    do_reset();
    div_in = 16'd6; mode_in = 1'b0; div_load = 1'b1;
    cyc();                         // edge 1: pending 6
    div_load = 1'b0;
    repeat (4) cyc();              // edges 2..5, 6 active from edge 4
    div_in = 16'd9; div_load = 1'b1;
    cyc();                         // edge 6: pending 9
    div_load = 1'b0;
    checks++;
    if (div_active !== 16'd6 || pend !== 1'b1 || clk_out !== 1'b1) begin
      failures++;
      $display("FAIL mid_setup div=%0d pend=%b clk_out=%b exp 6 1 1",
               div_active, pend, clk_out);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (clk_out !== 1'b0 || tick !== 1'b0 || div_active !== 16'd4 || pend !== 1'b0) begin
      failures++;
      $display("FAIL async_reset clk_out=%b tick=%b div=%0d pend=%b exp 0 0 4 0",
               clk_out, tick, div_active, pend);
    end
    rst_n = 1'b1;
    en = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      cyc();
      checks++;
      if (clk_out !== 1'b0 || tick !== 1'b0 || pend !== 1'b0 || div_active !== 16'd4) begin
        failures++;
        $display("FAIL en_low edge=%0d clk_out=%b tick=%b pend=%b div=%0d exp 0 0 0 4",
                 e, clk_out, tick, pend, div_active);
      end
    end
    en = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      cyc();
      exp_tick = (e == 4);
      checks++;
      if (tick !== exp_tick) begin
        failures++;
        $display("FAIL en_restart edge=%0d tick=%b exp %b", e, tick, exp_tick);
      end
    end
  endtask

  initial begin
    test_reset();
    test_reload();
    test_load_on_terminal();
    test_div_zero();
    test_last_wins();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Runtime-programmable clock divider and clock-enable generator for the lab's FPGA designs.
- Derives a slow square wave or a one-cycle pulse from clk_in, plus a single-cycle tick for use as a clock enable.
- Divisor and mode are reprogrammable while running. Changes apply only at period boundaries, so there are no runt periods.
- Sits between the board clock and the slow logic (display scan, debouncers, FSM steppers).

Parameters:
- CNT_W, 16: width of the divisor and the internal counter.
- DEFAULT_DIV, 4: active divisor after reset. Must satisfy 1 <= DEFAULT_DIV <= 2^CNT_W-1.
- DEFAULT_MODE, 0: active mode after reset. 0 = square, 1 = pulse.

Ports:
- clk_in  input  1  system clock; everything is on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  count enable.
- div_in  input  CNT_W  requested divisor D.
- mode_in  input  1  requested mode.
- div_load  input  1  one-cycle strobe that captures div_in and mode_in.
- clk_out  output  1  divided output, registered.
- tick  output  1  one-cycle pulse at each period boundary, registered.
- div_active  output  CNT_W  divisor currently in use.
- pend  output  1  a loaded request is waiting for a boundary.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - counter=0, clk_out=0, tick=0, pend=0.
  - div_active=DEFAULT_DIV, active mode=DEFAULT_MODE.
  - Outputs stay in this state until the first clk_in edge after rst_n rises. A reset mid-period discards any pending request.
- Terminal condition (en=1): counter==div_active-1.
  - At a terminal edge: counter<=0, tick<=1 for exactly one cycle.
  - Mode 0 at a terminal edge: clk_out toggles.
  - Mode 1 at a terminal edge: clk_out<=1 for one cycle, identical to tick.
  - At any other edge: counter<=counter+1, tick<=0. Mode 0 holds clk_out; mode 1 drives clk_out<=0.
- Output period:
  - Mode 0: square wave with period 2*D clk_in cycles and 50% duty.
  - Mode 1: pulse every D cycles.
  - D=1: mode 0 gives clk_in/2; mode 1 holds tick and clk_out high continuously.
- Latency: with en already high, the first tick and clk_out edge occur at the D-th rising edge after counting starts.
- Programming:
  - div_load=1 captures div_in and mode_in into pending registers and sets pend=1.
  - A captured div_in of 0 is stored as 1.
  - Pending values are copied into the active registers at the next terminal edge, which also clears pend. The first period with the new D begins at that edge.
  - div_load asserted on a terminal edge: div_in/mode_in go straight to active at that edge; pend stays 0.
  - div_load while pend=1: the new request overwrites the pending one (last wins).
  - On a mode change from 1 to 0 at a boundary, clk_out starts that period at 1 (it was just pulsed), then follows the toggle rule.
- Enable:
  - en=0: counter<=0, clk_out<=0, tick<=0.
  - en=0: any pending request, or a div_load in that cycle, becomes active at the next edge.
  - en rising: counting restarts from 0, with the first terminal after D cycles.
- Counter never exceeds div_active-1. No wrap at 2^CNT_W is possible.

Decomposition:
- Package clk_div_pkg holds:
  - constants MODE_SQUARE=1'b0, MODE_PULSE=1'b1;
  - default CNT_W=16;
  - function sanitising div 0 to 1.
- Sub-module clk_div_cfg holds the pending/active divisor and mode registers and pend, with inputs terminal, en, and div_load.
- Top level holds the counter and output registers.

Test Plan:
- Reset, en=1, defaults (D=4, mode 0):
  - clk_out rises at edge 4, falls at edge 8, rises at edge 12.
  - tick is high in the cycles after edges 4, 8 and 12 only.
- D=4, mode 0, counter=1: load div_in=2.
  - pend=1 until the edge-4 terminal.
  - From edge 4, toggles land at edges 6, 8, 10.
  - div_active reads 2 after edge 4.
- Load div_in=3 with mode_in=1 exactly on a terminal edge:
  - pend stays 0 and div_active=3 immediately.
  - clk_out pulses for one cycle every 3 cycles.
- Load div_in=0:
  - div_active becomes 1 at the boundary.
  - In mode 0, clk_out toggles every cycle.
- Two loads before a boundary (5, then 7): only 7 becomes active; 5 never appears on div_active.
- rst_n low for 1 ns mid-period with D=6 and a pending 9:
  - Outputs return to reset values asynchronously.
  - div_active=4 and pend=0 afterwards.
  - en=0 for 3 cycles then 1: first tick 4 cycles after en rises.
